regfile_wb_sched: RTL and testbench

Writeback scheduler and pending-write scoreboard for the 64-bit integer register file. Arbitrates NUM_REQ writeback requesters (ALU, LSU, MDU) onto the single register-file write port with round-robin fairness, registers the winning write, and tracks which architectural registers have an outstanding write so that issue logic can stall on RAW/WAW hazards. Sits between the execute/memory units and the register file's rd_wen/rd_addr/rd_data port.

---
 rtl/regfile_wb_sched.sv | 112 +++++++++++
 tb/tb_regfile_wb_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: round-robin arbitration of NUM_REQ writeback sources onto the
// single register-file write port, plus the pending-write scoreboard used for issue stalls.
module regfile_wb_sched #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 64,
  parameter int RAW     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*RAW-1:0]  req_rd_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_rd_data,
  input  logic                    iss_valid,
  input  logic [RAW-1:0]          iss_rd_addr,
  input  logic [RAW-1:0]          rs1_addr,
  input  logic [RAW-1:0]          rs2_addr,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [2**RAW-1:0]       busy_vec,
  output logic                    rf_wen,
  output logic [RAW-1:0]          rf_waddr,
  output logic [XLEN-1:0]         rf_wdata
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int NREG  = 2**RAW;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic             rf_wen_q, rf_wen_d;
  logic [RAW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;

  logic               gnt_vld;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [RAW-1:0]     gnt_addr;
  logic [XLEN-1:0]    gnt_data;

  // Requester index base+off, wrapped modulo NUM_REQ (off never exceeds NUM_REQ).
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[PTR_W-1:0];
  endfunction

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && req_valid[wrap_idx(rr_ptr_q, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_idx(rr_ptr_q, k);
      end
    end
    if (rst) gnt_vld = 1'b0;
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  assign gnt_addr  = req_rd_addr[gnt_idx*RAW +: RAW];
  assign gnt_data  = req_rd_data[gnt_idx*XLEN +: XLEN];
  assign req_ready = gnt_oh;

  // x0 writes retire the requester but are squashed before the register file.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt_vld) begin
      rr_ptr_d   = wrap_idx(gnt_idx, 1);
      rf_wen_d   = (gnt_addr != '0);
      rf_waddr_d = gnt_addr;
      rf_wdata_d = gnt_data;
    end
  end

  // Clear applies first so a same-edge issue to the committing register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
    if (iss_valid && (iss_rd_addr != '0)) busy_d[iss_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      busy_q     <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign busy_vec = busy_q;
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus randomized traffic against a
// cycle-level reference model of grants, the registered write port and the scoreboard.
module tb_regfile_wb_sched;

  localparam int N    = 3;
  localparam int XLEN = 64;
  localparam int RAW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*RAW-1:0]  req_rd_addr;
  logic [N*XLEN-1:0] req_rd_data;
  logic              iss_valid;
  logic [RAW-1:0]    iss_rd_addr, rs1_addr, rs2_addr;
  logic              rs1_busy, rs2_busy;
  logic [31:0]       busy_vec;
  logic              rf_wen;
  logic [RAW-1:0]    rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_ptr   = 0;
  bit [31:0]   m_busy  = '0;
  bit          m_wen   = 1'b0;
  bit [4:0]    m_waddr = '0;
  bit [63:0]   m_wdata = '0;

  regfile_wb_sched #(.NUM_REQ(N), .XLEN(XLEN), .RAW(RAW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd_addr(req_rd_addr), .req_rd_data(req_rd_data),
    .iss_valid(iss_valid), .iss_rd_addr(iss_rd_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_vec(busy_vec),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_edge();
    int g;
    bit [31:0] nb;
    g = model_grant();
    if (rst) begin
      m_ptr = 0; m_busy = '0; m_wen = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      nb = m_busy;
      if (m_wen) nb[m_waddr] = 1'b0;
      if (iss_valid && iss_rd_addr != 0) nb[iss_rd_addr] = 1'b1;
      m_busy = nb;
      if (g >= 0) begin
        m_ptr   = (g + 1) % N;
        m_waddr = req_rd_addr[g*RAW +: RAW];
        m_wdata = req_rd_data[g*XLEN +: XLEN];
        m_wen   = (m_waddr != 0);
      end else begin
        m_wen = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] a, input logic [63:0] d);
    req_valid[i] = v;
    req_rd_addr[i*RAW +: RAW] = a;
    req_rd_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    iss_valid = 1'b0;
    iss_rd_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    rs1_addr = '0; rs2_addr = '0;
    req_rd_addr = '0; req_rd_data = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 64'(i + 1));
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready0 got %b exp 000", req_ready); end
    tick();
    tick();
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready got %b exp 000", req_ready); end
    n_cmp++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b exp 0", rf_wen); end
    n_cmp++; if (busy_vec !== 32'h0) begin n_err++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
    n_cmp++; if (rf_waddr !== 5'd0 || rf_wdata !== 64'h0) begin n_err++; $display("FAIL reset_wport got %0d/%h exp 0/0", rf_waddr, rf_wdata); end
    rst = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL first_grant got %b exp 001", req_ready); end
    tick();
    req_valid = '0;
    #1;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd1) begin n_err++; $display("FAIL first_write got %b/%0d exp 1/1", rf_wen, rf_waddr); end
    tick();
  endtask

  task automatic test_single_write();
    iss_valid = 1'b1; iss_rd_addr = 5'd5; rs1_addr = 5'd5;
    tick();                                   // N+1
    iss_valid = 1'b0;
    n_cmp++; if (busy_vec[5] !== 1'b1 || rs1_busy !== 1'b1) begin n_err++; $display("FAIL sw_busy_n1 got %b/%b exp 1/1", busy_vec[5], rs1_busy); end
    tick();                                   // N+2
    set_req(0, 1'b1, 5'd5, 64'hDEAD_BEEF_CAFE_BABE);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL sw_ready got %b exp 001", req_ready); end
    n_cmp++; if (busy_vec[5] !== 1'b1) begin n_err++; $display("FAIL sw_busy_n2 got %b exp 1", busy_vec[5]); end
    tick();                                   // N+3
    req_valid = '0;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'hDEAD_BEEF_CAFE_BABE)
      begin n_err++; $display("FAIL sw_write got %b/%0d/%h exp 1/5/deadbeefcafebabe", rf_wen, rf_waddr, rf_wdata); end
    n_cmp++; if (busy_vec[5] !== 1'b1) begin n_err++; $display("FAIL sw_busy_n3 got %b exp 1", busy_vec[5]); end
    tick();                                   // N+4
    n_cmp++; if (busy_vec[5] !== 1'b0 || rs1_busy !== 1'b0 || rf_wen !== 1'b0)
      begin n_err++; $display("FAIL sw_clear got busy %b rs1 %b wen %b exp 0/0/0", busy_vec[5], rs1_busy, rf_wen); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c <= 6; c++) begin
      for (int i = 0; i < N; i++) set_req(i, c < 6, 5'(i + 1), 64'h0123_4567_89AB_CDE0 + 64'(i));
      #1;
      if (c < 6) begin
        n_cmp++; if (req_ready !== 3'(1 << (c % 3))) begin n_err++; $display("FAIL rr_grant c%0d got %b exp %b", c, req_ready, 3'(1 << (c % 3))); end
      end
      if (c > 0) begin
        n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'((c - 1) % 3 + 1) || rf_wdata !== 64'h0123_4567_89AB_CDE0 + 64'((c - 1) % 3))
          begin n_err++; $display("FAIL rr_write c%0d got %b/%0d/%h exp 1/%0d", c, rf_wen, rf_waddr, rf_wdata, (c - 1) % 3 + 1); end
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_x0();
    set_req(1, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    iss_valid = 1'b1; iss_rd_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL x0_ready got %b exp 010", req_ready); end
    tick();
    idle_inputs();
    n_cmp++; if (rf_wen !== 1'b0) begin n_err++; $display("FAIL x0_wen got %b exp 0", rf_wen); end
    n_cmp++; if (busy_vec !== 32'h0 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
      begin n_err++; $display("FAIL x0_busy got %h/%b/%b exp 0", busy_vec, rs1_busy, rs2_busy); end
    tick();
  endtask

  task automatic test_collision();
    iss_valid = 1'b1; iss_rd_addr = 5'd7;
    tick();
    iss_valid = 1'b0;
    set_req(0, 1'b1, 5'd7, 64'h7777_0000_7777_0000);
    tick();
    req_valid = '0;
    iss_valid = 1'b1; iss_rd_addr = 5'd7;
    n_cmp++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin n_err++; $display("FAIL col_write got %b/%0d exp 1/7", rf_wen, rf_waddr); end
    tick();
    iss_valid = 1'b0;
    n_cmp++; if (busy_vec[7] !== 1'b1) begin n_err++; $display("FAIL col_set_wins got %b exp 1", busy_vec[7]); end
    tick();
    n_cmp++; if (busy_vec[7] !== 1'b1) begin n_err++; $display("FAIL col_hold got %b exp 1", busy_vec[7]); end
    set_req(0, 1'b1, 5'd7, 64'h1);
    tick();
    req_valid = '0;
    tick();
    n_cmp++; if (busy_vec[7] !== 1'b0) begin n_err++; $display("FAIL col_clear got %b exp 0", busy_vec[7]); end
  endtask

  task automatic test_reset_midflight();
    iss_valid = 1'b1; iss_rd_addr = 5'd9;
    tick();
    iss_valid = 1'b0;
    set_req(2, 1'b1, 5'd9, 64'h1111_1111_1111_1111);
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL mf_accept got %b exp 100", req_ready); end
    tick();
    rst = 1'b1;
    iss_valid = 1'b1; iss_rd_addr = 5'd9;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL mf_ready_forced got %b exp 000", req_ready); end
    tick();
    rst = 1'b0;
    idle_inputs();
    n_cmp++; if (rf_wen !== 1'b0 || busy_vec !== 32'h0) begin n_err++; $display("FAIL mf_discard got wen %b busy %h exp 0/0", rf_wen, busy_vec); end
    tick();
    n_cmp++; if (rf_wen !== 1'b0 || busy_vec[9] !== 1'b0) begin n_err++; $display("FAIL mf_after got wen %b busy9 %b exp 0/0", rf_wen, busy_vec[9]); end
  endtask

  task automatic test_random();
    int eg;
    logic [2:0] exp_rdy;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      req_valid = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        req_rd_addr[i*RAW +: RAW] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        req_rd_data[i*XLEN +: XLEN] = {$urandom, $urandom};
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd_addr = 5'($urandom_range(0, 31));
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = 5'($urandom_range(0, 31));
      #1;
      eg = model_grant();
      exp_rdy = (eg < 0) ? 3'b000 : 3'(1 << eg);
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready c%0d got %b exp %b", c, req_ready, exp_rdy); end
      n_cmp++; if (rf_wen !== m_wen || rf_waddr !== m_waddr || rf_wdata !== m_wdata)
        begin n_err++; $display("FAIL rnd_wport c%0d got %b/%0d/%h exp %b/%0d/%h", c, rf_wen, rf_waddr, rf_wdata, m_wen, m_waddr, m_wdata); end
      n_cmp++; if (busy_vec !== m_busy || rs1_busy !== m_busy[rs1_addr] || rs2_busy !== m_busy[rs2_addr])
        begin n_err++; $display("FAIL rnd_busy c%0d got %h/%b/%b exp %h", c, busy_vec, rs1_busy, rs2_busy, m_busy); end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_x0();
    test_collision();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
